pl_reg_skid: RTL and testbench

PL_REG_SKID -- requirements
Module: pl_reg_skid

---
 rtl/pl_reg_skid_pkg.sv | 18 +
 rtl/pl_entry.sv | 41 ++++
 rtl/pl_reg_skid.sv | 136 +++++++++++++
 tb/tb_pl_reg_skid.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pl_reg_skid_pkg.sv
// Shared pipeline definitions: thread-count derivation and the D/E payload layout.
package pl_reg_skid_pkg;

   // D/E control and datapath bundle field offsets within the payload
   localparam int unsigned PL_OPC_LSB  = 0;
   localparam int unsigned PL_OPC_W    = 7;
   localparam int unsigned PL_RD_LSB   = PL_OPC_LSB + PL_OPC_W;
   localparam int unsigned PL_RD_W     = 5;
   localparam int unsigned PL_IMM_LSB  = PL_RD_LSB + PL_RD_W;
   localparam int unsigned PL_IMM_W    = 20;
   localparam int unsigned PL_DE_WIDTH = PL_IMM_LSB + PL_IMM_W;

   // Number of hardware threads addressable by a thread ID of the given width
   function automatic int unsigned num_threads(input int unsigned bits_threads);
      return 32'd1 << bits_threads;
   endfunction

endpackage

// File: rtl/pl_entry.sv
// One pipeline slot: valid bit plus thread ID and payload, with load/kill/drop control.
// Priority: load > kill (invalidate, optionally zero fields) > drop (invalidate only).
module pl_entry #(
   parameter int unsigned DATA_WIDTH   = 32,
   parameter int unsigned BITS_THREADS = 3,
   parameter int unsigned ZERO_ON_KILL = 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    load,
   input  logic                    kill,
   input  logic                    drop,
   input  logic [BITS_THREADS-1:0] d_tid,
   input  logic [DATA_WIDTH-1:0]   d_data,
   output logic                    valid,
   output logic [BITS_THREADS-1:0] tid,
   output logic [DATA_WIDTH-1:0]   data
);

   // Slot register; killed slots are scrubbed when ZERO_ON_KILL is set
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid <= 1'b0;
         tid   <= '0;
         data  <= '0;
      end else if (load) begin
         valid <= 1'b1;
         tid   <= d_tid;
         data  <= d_data;
      end else if (kill) begin
         valid <= 1'b0;
         if (ZERO_ON_KILL != 0) begin
            tid  <= '0;
            data <= '0;
         end
      end else if (drop) begin
         valid <= 1'b0;
      end
   end

endmodule

// File: rtl/pl_reg_skid.sv
// Two-entry registered pipeline stage with skid slot, per-thread flush and
// saturating kill counter. All outputs come straight from registers.
module pl_reg_skid
   import pl_reg_skid_pkg::*;
#(
   parameter int unsigned DATA_WIDTH   = PL_DE_WIDTH,
   parameter int unsigned BITS_THREADS = 3,
   parameter int unsigned ZERO_ON_KILL = 1,
   parameter int unsigned CNT_WIDTH    = 8,
   localparam int unsigned NUM_THREADS = num_threads(BITS_THREADS)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    clr,
   input  logic [NUM_THREADS-1:0]  flush_mask,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [BITS_THREADS-1:0] in_tid,
   input  logic [DATA_WIDTH-1:0]   in_data,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [BITS_THREADS-1:0] out_tid,
   output logic [DATA_WIDTH-1:0]   out_data,
   output logic [1:0]              occupancy,
   output logic [CNT_WIDTH-1:0]    kill_cnt
);

   logic                    main_v, skid_v;
   logic [BITS_THREADS-1:0] main_tid, skid_tid;
   logic [DATA_WIDTH-1:0]   main_data, skid_data;

   logic                    in_xfer, out_xfer;
   logic                    m_kill, m_surv, s_kill, s_surv, i_kill, i_app;
   logic                    main_load, main_kill, main_drop;
   logic                    skid_load, skid_kill, skid_drop;
   logic [BITS_THREADS-1:0] main_d_tid;
   logic [DATA_WIDTH-1:0]   main_d_data;
   logic [1:0]              kill_add;
   logic [CNT_WIDTH+1:0]    kill_sum;

   assign in_ready  = ~skid_v;
   assign out_valid = main_v;
   assign out_tid   = main_tid;
   assign out_data  = main_data;
   assign occupancy = {1'b0, main_v} + {1'b0, skid_v};

   // Next-state: deliver main, kill flushed threads, append input, compact toward main.
   // Input only transfers when skid is empty, so at most two beats ever survive.
   always_comb begin
      in_xfer     = in_valid & ~skid_v;
      out_xfer    = main_v & out_ready;
      m_kill      = main_v & ~out_xfer & flush_mask[main_tid];
      m_surv      = main_v & ~out_xfer & ~flush_mask[main_tid];
      s_kill      = skid_v & flush_mask[skid_tid];
      s_surv      = skid_v & ~flush_mask[skid_tid];
      i_kill      = in_xfer & flush_mask[in_tid];
      i_app       = in_xfer & ~flush_mask[in_tid];
      main_load   = 1'b0;
      main_kill   = 1'b0;
      main_drop   = 1'b0;
      skid_load   = 1'b0;
      skid_kill   = 1'b0;
      skid_drop   = 1'b0;
      main_d_tid  = in_tid;
      main_d_data = in_data;
      kill_add    = 2'd0;
      if (clr) begin
         main_kill = 1'b1;
         skid_kill = 1'b1;
         kill_add  = {1'b0, main_v} + {1'b0, skid_v} + {1'b0, in_xfer};
      end else begin
         kill_add = {1'b0, m_kill} + {1'b0, s_kill} + {1'b0, i_kill};
         if (m_surv) begin
            skid_load = i_app;
            skid_kill = s_kill;
         end else begin
            main_load = s_surv | i_app;
            if (s_surv) begin
               main_d_tid  = skid_tid;
               main_d_data = skid_data;
            end
            main_kill = m_kill & ~main_load;
            main_drop = out_xfer & ~main_load;
            skid_kill = s_kill;
            skid_drop = s_surv;
         end
      end
      kill_sum = {2'b00, kill_cnt} + {{CNT_WIDTH{1'b0}}, kill_add};
   end

   // Kill counter saturates at all-ones instead of wrapping
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         kill_cnt <= '0;
      end else if (|kill_sum[CNT_WIDTH+1:CNT_WIDTH]) begin
         kill_cnt <= '1;
      end else begin
         kill_cnt <= kill_sum[CNT_WIDTH-1:0];
      end
   end

   pl_entry #(
      .DATA_WIDTH   (DATA_WIDTH),
      .BITS_THREADS (BITS_THREADS),
      .ZERO_ON_KILL (ZERO_ON_KILL)
   ) u_main (
      .clk    (clk),
      .rst_n  (rst_n),
      .load   (main_load),
      .kill   (main_kill),
      .drop   (main_drop),
      .d_tid  (main_d_tid),
      .d_data (main_d_data),
      .valid  (main_v),
      .tid    (main_tid),
      .data   (main_data)
   );

   pl_entry #(
      .DATA_WIDTH   (DATA_WIDTH),
      .BITS_THREADS (BITS_THREADS),
      .ZERO_ON_KILL (ZERO_ON_KILL)
   ) u_skid (
      .clk    (clk),
      .rst_n  (rst_n),
      .load   (skid_load),
      .kill   (skid_kill),
      .drop   (skid_drop),
      .d_tid  (in_tid),
      .d_data (in_data),
      .valid  (skid_v),
      .tid    (skid_tid),
      .data   (skid_data)
   );

endmodule

// File: tb/tb_pl_reg_skid.sv
// Bench for pl_reg_skid: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_pl_reg_skid;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        clr = 1'b0;
   logic [7:0]  flush_mask = '0;
   logic        in_valid = 1'b0;
   logic [2:0]  in_tid = '0;
   logic [31:0] in_data = '0;
   logic        out_ready = 1'b0;

   logic        in_ready, out_valid, in_ready2, out_valid2;
   logic [2:0]  out_tid, out_tid2;
   logic [31:0] out_data, out_data2;
   logic [1:0]  occupancy, occupancy2;
   logic [7:0]  kill_cnt;
   logic [1:0]  kill_cnt2;

   int unsigned n_vec = 0;
   int unsigned n_err = 0;
   bit          check_en = 1'b0;

   typedef struct packed {
      logic [2:0]  tid;
      logic [31:0] data;
   } beat_t;
   beat_t       q[$];
   int unsigned kc8 = 0;
   int unsigned kc2 = 0;

   always #5 clk = ~clk;

   pl_reg_skid dut (
      .clk(clk), .rst_n(rst_n), .clr(clr), .flush_mask(flush_mask),
      .in_valid(in_valid), .in_ready(in_ready), .in_tid(in_tid), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_tid(out_tid), .out_data(out_data),
      .occupancy(occupancy), .kill_cnt(kill_cnt)
   );

   pl_reg_skid #(.CNT_WIDTH(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .clr(clr), .flush_mask(flush_mask),
      .in_valid(in_valid), .in_ready(in_ready2), .in_tid(in_tid), .in_data(in_data),
      .out_valid(out_valid2), .out_ready(out_ready), .out_tid(out_tid2), .out_data(out_data2),
      .occupancy(occupancy2), .kill_cnt(kill_cnt2)
   );

   task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: ordered list of held beats, updated by the transfer rules
   always @(posedge clk) begin
      if (rst_n) begin
         int unsigned add;
         bit inx;
         add = 0;
         inx = in_valid && (q.size() < 2);
         if (clr) begin
            add = q.size() + (inx ? 1 : 0);
            q.delete();
         end else begin
            if (q.size() > 0 && out_ready) void'(q.pop_front());
            for (int i = int'(q.size()) - 1; i >= 0; i--) begin
               if (flush_mask[q[i].tid]) begin
                  q.delete(i);
                  add++;
               end
            end
            if (inx) begin
               if (flush_mask[in_tid]) add++;
               else q.push_back('{tid: in_tid, data: in_data});
            end
         end
         kc8 = (kc8 + add > 255) ? 255 : kc8 + add;
         kc2 = (kc2 + add > 3) ? 3 : kc2 + add;
      end
   end

   // Compare DUT outputs with the model away from the active edge
   always @(negedge clk) begin
      if (check_en) begin
         chk("out_valid", out_valid, q.size() > 0);
         chk("in_ready", in_ready, q.size() < 2);
         chk("occupancy", occupancy, q.size());
         chk("kill_cnt", kill_cnt, kc8);
         chk("occupancy_w2", occupancy2, q.size());
         chk("kill_cnt_w2", kill_cnt2, kc2);
         if (q.size() > 0) begin
            chk("out_tid", out_tid, q[0].tid);
            chk("out_data", out_data, q[0].data);
            chk("out_data_w2", out_data2, q[0].data);
         end
      end
   end

   task automatic drive(input bit v, input logic [2:0] t, input logic [31:0] d);
      in_valid = v;
      in_tid   = t;
      in_data  = d;
   endtask

   task automatic idle();
      drive(1'b0, 3'd0, 32'd0);
      flush_mask = '0;
      clr = 1'b0;
   endtask

   // Mixed traffic: {in_valid, tid, data, out_ready, flush_mask}
   typedef struct packed {
      logic        v;
      logic [2:0]  t;
      logic [31:0] d;
      logic        ordy;
      logic [7:0]  fm;
   } vec_t;
   vec_t mix[12];

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      mix[0]  = '{1'b1, 3'd0, 32'hB0, 1'b0, 8'h00};
      mix[1]  = '{1'b1, 3'd1, 32'hB1, 1'b0, 8'h00};
      mix[2]  = '{1'b1, 3'd2, 32'hB2, 1'b0, 8'h01};
      mix[3]  = '{1'b1, 3'd3, 32'hB3, 1'b1, 8'h00};
      mix[4]  = '{1'b1, 3'd4, 32'hB4, 1'b0, 8'h10};
      mix[5]  = '{1'b1, 3'd5, 32'hB5, 1'b0, 8'h00};
      mix[6]  = '{1'b1, 3'd6, 32'hB6, 1'b0, 8'h00};
      mix[7]  = '{1'b0, 3'd0, 32'h00, 1'b0, 8'h22};
      mix[8]  = '{1'b1, 3'd7, 32'hB7, 1'b1, 8'h40};
      mix[9]  = '{1'b1, 3'd7, 32'hB8, 1'b1, 8'h00};
      mix[10] = '{1'b1, 3'd1, 32'hB9, 1'b1, 8'h80};
      mix[11] = '{1'b0, 3'd0, 32'h00, 1'b1, 8'h00};

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_occupancy", occupancy, 0);
      chk("rst_kill_cnt", kill_cnt, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_out_tid", out_tid, 0);
      rst_n = 1'b1;
      check_en = 1'b1;

      // Streaming at full rate
      out_ready = 1'b1;
      drive(1'b1, 3'd0, 32'hA0);
      @(negedge clk); chk("stream_a0", out_data, 32'hA0);
      drive(1'b1, 3'd1, 32'hA1);
      @(negedge clk); chk("stream_a1", out_data, 32'hA1); chk("stream_occ", occupancy, 1);
      drive(1'b1, 3'd2, 32'hA2);
      @(negedge clk); chk("stream_a2", out_data, 32'hA2); chk("stream_tid2", out_tid, 2);
      idle();
      @(negedge clk); chk("stream_empty", occupancy, 0);

      // Backpressure fills skid, then drains in order
      out_ready = 1'b0;
      drive(1'b1, 3'd1, 32'h10);
      @(negedge clk);
      drive(1'b1, 3'd2, 32'h11);
      @(negedge clk);
      chk("bp_occ", occupancy, 2); chk("bp_in_ready", in_ready, 0); chk("bp_first", out_data, 32'h10);
      idle();
      out_ready = 1'b1;
      @(negedge clk); chk("bp_second", out_data, 32'h11); chk("bp_occ1", occupancy, 1);
      @(negedge clk); chk("bp_empty", occupancy, 0);

      // Flush of main's thread promotes skid
      out_ready = 1'b0;
      drive(1'b1, 3'd3, 32'h33);
      @(negedge clk);
      drive(1'b1, 3'd5, 32'h55);
      @(negedge clk);
      idle();
      flush_mask = 8'h08;
      @(negedge clk);
      chk("fl_tid", out_tid, 5); chk("fl_data", out_data, 32'h55);
      chk("fl_occ", occupancy, 1); chk("fl_kc", kill_cnt, 1);
      flush_mask = '0;
      out_ready = 1'b1;
      @(negedge clk);

      // Delivery wins over same-cycle flush; flushed input is dropped
      out_ready = 1'b0;
      drive(1'b1, 3'd2, 32'h22);
      @(negedge clk);
      chk("sim_main", out_data, 32'h22);
      out_ready = 1'b1;
      drive(1'b1, 3'd2, 32'h23);
      flush_mask = 8'h04;
      @(negedge clk);
      chk("sim_occ", occupancy, 0); chk("sim_kc", kill_cnt, 2);
      idle();

      // clr with a full block (input offered but not transferable)
      out_ready = 1'b0;
      drive(1'b1, 3'd0, 32'h01);
      @(negedge clk);
      drive(1'b1, 3'd1, 32'h02);
      @(negedge clk);
      drive(1'b1, 3'd6, 32'h03);
      clr = 1'b1;
      @(negedge clk);
      chk("clr_occ", occupancy, 0); chk("clr_data", out_data, 0); chk("clr_tid", out_tid, 0);
      chk("clr_kc", kill_cnt, 4); chk("clr_kc_sat", kill_cnt2, 3);
      idle();
      // clr with one entry plus a transferring input
      drive(1'b1, 3'd4, 32'h44);
      @(negedge clk);
      drive(1'b1, 3'd5, 32'h45);
      clr = 1'b1;
      @(negedge clk);
      chk("clr2_occ", occupancy, 0); chk("clr2_kc", kill_cnt, 6); chk("clr2_kc_sat", kill_cnt2, 3);
      idle();

      // Mixed traffic against the model
      foreach (mix[i]) begin
         drive(mix[i].v, mix[i].t, mix[i].d);
         out_ready  = mix[i].ordy;
         flush_mask = mix[i].fm;
         @(negedge clk);
      end
      idle();
      out_ready = 1'b1;
      repeat (3) @(negedge clk);

      // Asynchronous reset with two entries held
      out_ready = 1'b0;
      drive(1'b1, 3'd6, 32'h66);
      @(negedge clk);
      drive(1'b1, 3'd7, 32'h77);
      @(negedge clk);
      chk("ar_pre_occ", occupancy, 2);
      drive(1'b1, 3'd1, 32'h99);
      #2;
      check_en = 1'b0;
      rst_n = 1'b0;
      q.delete();
      kc8 = 0;
      kc2 = 0;
      #1;
      chk("ar_out_valid", out_valid, 0); chk("ar_in_ready", in_ready, 1);
      chk("ar_occ", occupancy, 0); chk("ar_kc", kill_cnt, 0); chk("ar_data", out_data, 0);
      @(negedge clk);
      idle();
      rst_n = 1'b1;
      #1;
      chk("ar_post_occ", occupancy, 0); chk("ar_post_valid", out_valid, 0);
      check_en = 1'b1;
      repeat (2) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
